// File: rtl/sbox_rr_scheduler_if.sv
// sbox_rr_scheduler_if: requester-side handshake bundle (requests, randomness, responses).
interface sbox_rr_scheduler_if #(parameter int d = 4, parameter int NREQ = 4);
   localparam int W = 8 + d;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              rand_valid;
   logic              rand_ready;
   logic [NREQ-1:0]   resp_valid;
   logic [W-1:0]      resp_data;
   modport master (output req_valid, req_data, rand_valid,
                   input  req_ready, rand_ready, resp_valid, resp_data);
   modport slave  (input  req_valid, req_data, rand_valid,
                   output req_ready, rand_ready, resp_valid, resp_data);
endinterface

// File: rtl/sbox_rr_scheduler.sv
// sbox_rr_scheduler: round-robin sharing of one pipelined masked S-box among NREQ byte requesters,
// with a tag pipeline that routes each result back to its requester after a fixed LAT+2 cycles.
module sbox_rr_scheduler #(
   parameter int d    = 4,
   parameter int NREQ = 4,
   parameter int LAT  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sbox_rr_scheduler_if.slave   bus,
   output logic [d+7:0]         o_sbox_in,
   output logic                 o_sbox_en,
   input  logic [d+7:0]         i_sbox_out,
   output logic                 o_busy
);
   localparam int W  = 8 + d;
   localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;

   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   w_idx;
   logic [IW-1:0]   w_cand;
   logic [IW-1:0]   w_ptr_nxt;
   logic            w_issue;
   logic            r_en;
   logic [IW-1:0]   r_id;
   logic [W-1:0]    r_sbox_in;
   logic [LAT-1:0]  r_tv;
   logic [IW-1:0]   r_tid [LAT];
   logic [NREQ-1:0] r_resp_valid;
   logic [W-1:0]    r_resp_data;

   // Descending search so the lowest offset from r_ptr wins.
   always_comb begin
      w_idx  = r_ptr;
      w_cand = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_cand = IW'((int'(r_ptr) + k) % NREQ);
         if (bus.req_valid[w_cand]) w_idx = w_cand;
      end
   end

   assign w_issue        = rst_n & bus.rand_valid & (|bus.req_valid);
   assign w_ptr_nxt      = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
   assign bus.req_ready  = w_issue ? NREQ'(1) << w_idx : '0;
   assign bus.rand_ready = w_issue;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_data  = r_resp_data;
   assign o_sbox_in      = r_sbox_in;
   assign o_sbox_en      = r_en;
   assign o_busy         = (|bus.req_ready) | r_en | (|r_tv) | (|r_resp_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr        <= '0;
         r_en         <= 1'b0;
         r_id         <= '0;
         r_sbox_in    <= '0;
         r_tv         <= '0;
         r_resp_valid <= '0;
         r_resp_data  <= '0;
         for (int k = 0; k < LAT; k++) r_tid[k] <= '0;
      end else begin
         if (w_issue) r_ptr <= w_ptr_nxt;
         r_en      <= w_issue;
         r_id      <= w_issue ? w_idx : '0;
         r_sbox_in <= w_issue ? bus.req_data[w_idx*W +: W] : '0;
         r_tv[0]   <= r_en;
         r_tid[0]  <= r_id;
         for (int k = 1; k < LAT; k++) begin
            r_tv[k]  <= r_tv[k-1];
            r_tid[k] <= r_tid[k-1];
         end
         r_resp_valid <= r_tv[LAT-1] ? NREQ'(1) << r_tid[LAT-1] : '0;
         r_resp_data  <= r_tv[LAT-1] ? i_sbox_out : '0;
      end
   end
endmodule
